// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared FSM encodings, bus constants, request type and lane-alignment helper
package dmem_responder_pkg;

   localparam logic [1:0]  ST_IDLE       = 2'b00;
   localparam logic [1:0]  ST_WAIT       = 2'b01;
   localparam logic [1:0]  ST_ACCESS     = 2'b10;

   localparam logic        CHIP_ENABLE   = 1'b1;
   localparam logic        WRITE_ENABLE  = 1'b1;
   localparam logic        WRITE_DISABLE = 1'b0;
   localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  sel;
      logic [31:0] data;
   } dmem_req_t;

   // Big-endian lanes: sel[3] is the byte at offset 00.
   function automatic logic align_ok(input logic [3:0] sel, input logic [1:0] lane);
      case (sel)
         4'b1111, 4'b1100: align_ok = (lane == 2'b00);
         4'b0011:          align_ok = (lane == 2'b10);
         4'b1000:          align_ok = (lane == 2'b00);
         4'b0100:          align_ok = (lane == 2'b01);
         4'b0010:          align_ok = (lane == 2'b10);
         4'b0001:          align_ok = (lane == 2'b11);
         default:          align_ok = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - 2^DEPTH_LOG2 x 32 storage with byte-lane synchronous write and registered read
module dmem_array
   import dmem_responder_pkg::*;
#(
   parameter int DEPTH_LOG2 = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [3:0]            wr_be,
   input  logic [DEPTH_LOG2-1:0] wr_idx,
   input  logic [31:0]           wr_data,
   input  logic                  rd_en,
   input  logic [DEPTH_LOG2-1:0] rd_idx,
   output logic [31:0]           rd_data
);

   logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (wr_be[i]) begin
            mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
         end
      end
   end

   // Only the read register is reset; storage contents survive reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_data <= ZERO_WORD;
      end else if (rd_en) begin
         rd_data <= mem[rd_idx];
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - MEM-stage data memory target: FSM, request latch, wait counter, stall and ack
// Optional alignment check enabled by defining DMEM_ALIGN_CHK_EN.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int DEPTH_LOG2  = 10,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ce_i,
   input  logic        we_i,
   input  logic [31:0] addr_i,
   input  logic [3:0]  sel_i,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   output logic        ack_o,
   output logic        err_o,
   output logic        stallreq_o
);

   localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   logic [1:0] state, state_nxt;
   logic [3:0] cnt;
   dmem_req_t  req_q, req_eff;
   logic       err_eff, err_acc;
   logic [3:0] wr_be;
   logic       rd_en;
   logic       unused_addr_bits;

   // In IDLE the live bus is the request; afterwards only the latched copy counts.
   assign req_eff = (state == ST_IDLE) ? {we_i, addr_i, sel_i, data_i} : req_q;

`ifdef DMEM_ALIGN_CHK_EN
   assign err_eff = !align_ok(req_eff.sel, req_eff.addr[1:0]);
   assign err_acc = !align_ok(req_q.sel, req_q.addr[1:0]);
`else
   assign err_eff = 1'b0;
   assign err_acc = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (ce_i == CHIP_ENABLE) begin
               state_nxt = (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;
            end
         end
         ST_WAIT: begin
            if (ce_i != CHIP_ENABLE) begin
               state_nxt = ST_IDLE;
            end else if (cnt == 4'd0) begin
               state_nxt = ST_ACCESS;
            end
         end
         ST_ACCESS: state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
         cnt   <= 4'd0;
         req_q <= '0;
      end else begin
         state <= state_nxt;
         if (state == ST_IDLE && ce_i == CHIP_ENABLE) begin
            req_q <= req_eff;
            cnt   <= CNT_LOAD;
         end else if (state == ST_WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end
      end
   end

   // The read is launched on the edge entering ACCESS so data_o is valid alongside ack_o.
   assign rd_en = (state_nxt == ST_ACCESS) && (req_eff.we == WRITE_DISABLE) && !err_eff;
   assign wr_be = (state == ST_ACCESS && req_q.we == WRITE_ENABLE && !err_acc) ? req_q.sel : 4'b0000;

   dmem_array #(
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_array (
      .clk     (clk),
      .rst     (rst),
      .wr_be   (wr_be),
      .wr_idx  (req_q.addr[DEPTH_LOG2+1:2]),
      .wr_data (req_q.data),
      .rd_en   (rd_en),
      .rd_idx  (req_eff.addr[DEPTH_LOG2+1:2]),
      .rd_data (data_o)
   );

   assign ack_o      = (state == ST_ACCESS);
   assign err_o      = ack_o & err_acc;
   assign stallreq_o = ce_i & ~ack_o;

   assign unused_addr_bits = ^{req_q.addr[31:DEPTH_LOG2+2], req_q.addr[1:0]};

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder; expectations track DMEM_ALIGN_CHK_EN
module tb_dmem_responder;

   localparam int WAIT = 2;
`ifdef DMEM_ALIGN_CHK_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif

   typedef struct {
      logic [31:0] data;
      logic        err;
      int          stall;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ce_i = 1'b0;
   logic        we_i = 1'b0;
   logic [31:0] addr_i = '0;
   logic [3:0]  sel_i = '0;
   logic [31:0] data_i = '0;
   logic [31:0] data_o;
   logic        ack_o, err_o, stallreq_o;

   exp_t        exp_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          last_ack = 0;
   int          prev_ack = 0;
   int          ack_count = 0;
   logic [31:0] last_rd = 32'h0;

   dmem_responder #(
      .DEPTH_LOG2  (10),
      .WAIT_CYCLES (WAIT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ce_i       (ce_i),
      .we_i       (we_i),
      .addr_i     (addr_i),
      .sel_i      (sel_i),
      .data_i     (data_i),
      .data_o     (data_o),
      .ack_o      (ack_o),
      .err_o      (err_o),
      .stallreq_o (stallreq_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every ack pops one expectation; stall cycles preceding it measure latency.
   initial begin
      int   stall_run;
      exp_t e;
      stall_run = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            stall_run = 0;
         end else if (ack_o) begin
            ack_count++;
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_ack: got ack with empty scoreboard (cycle %0d)", cyc);
            end else begin
               e = exp_q.pop_front();
               chk("ack_data", data_o, e.data);
               chk("ack_err", {31'b0, err_o}, {31'b0, e.err});
               chk("stall_cycles", stall_run, e.stall);
            end
            prev_ack  = last_ack;
            last_ack  = cyc;
            stall_run = 0;
         end else if (stallreq_o) begin
            stall_run++;
         end else begin
            stall_run = 0;
         end
      end
   end

   task automatic push_exp(input logic we, input logic [31:0] rd, input logic err);
      exp_t e;
      if (!we && !err) last_rd = rd;
      e.data  = last_rd;
      e.err   = err;
      e.stall = WAIT + 1;
      exp_q.push_back(e);
   endtask

   task automatic wait_ack();
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (ack_o) return;
      end
      n_cmp++;
      n_bad++;
      $display("FAIL ack_timeout: no ack within 40 cycles (cycle %0d)", cyc);
   endtask

   // Inputs are scrambled once the request is accepted to show only latched values matter.
   task automatic do_req(input logic we, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d, input logic [31:0] rd, input logic err);
      @(posedge clk); #1;
      ce_i = 1'b1; we_i = we; addr_i = a; sel_i = s; data_i = d;
      push_exp(we, rd, err);
      @(posedge clk); #1;
      we_i = ~we; addr_i = ~a; sel_i = ~s; data_i = ~d;
      wait_ack();
      @(posedge clk); #1;
      ce_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int acks_before;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_data", data_o, 32'h0);
      chk("reset_ack", {31'b0, ack_o}, 32'h0);
      chk("reset_err", {31'b0, err_o}, 32'h0);
      chk("reset_stall", {31'b0, stallreq_o}, 32'h0);
      rst = 1'b1;

      do_req(1'b1, 32'h10, 4'b1111, 32'hDEADBEEF, 32'h0, 1'b0);
      do_req(1'b0, 32'h10, 4'b1111, 32'h0, 32'hDEADBEEF, 1'b0);
      do_req(1'b1, 32'h11, 4'b0100, 32'h00AA0000, 32'h0, 1'b0);
      do_req(1'b0, 32'h10, 4'b1111, 32'h0, 32'hDEAABEEF, 1'b0);
      do_req(1'b1, 32'h14, 4'b1111, 32'h01234567, 32'h0, 1'b0);

      // Abort: read of 0x14 dropped after one WAIT cycle.
      acks_before = ack_count;
      @(posedge clk); #1;
      ce_i = 1'b1; we_i = 1'b0; addr_i = 32'h14; sel_i = 4'b1111;
      @(posedge clk); #1;
      @(posedge clk); #1;
      ce_i = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      chk("abort_no_ack", ack_count, acks_before);
      chk("abort_data_held", data_o, 32'hDEAABEEF);

      // Back-to-back reads with ce_i held high.
      @(posedge clk); #1;
      ce_i = 1'b1; we_i = 1'b0; addr_i = 32'h10; sel_i = 4'b1111;
      push_exp(1'b0, 32'hDEAABEEF, 1'b0);
      wait_ack();
      @(posedge clk); #1;
      addr_i = 32'h14;
      push_exp(1'b0, 32'h01234567, 1'b0);
      wait_ack();
      @(posedge clk); #1;
      ce_i = 1'b0;
      chk("b2b_ack_spacing", last_ack - prev_ack, 4);

      do_req(1'b1, 32'h14, 4'b0000, 32'hFFFFFFFF, 32'h0, ALIGN);
      do_req(1'b0, 32'h14, 4'b1111, 32'h0, 32'h01234567, 1'b0);
      do_req(1'b0, 32'h1010, 4'b1111, 32'h0, 32'hDEAABEEF, 1'b0);
      do_req(1'b1, 32'h20, 4'b1111, 32'h12345678, 32'h0, 1'b0);
      do_req(1'b0, 32'h20, 4'b1111, 32'h0, 32'h12345678, 1'b0);

      // Reset asserted during the WAIT of a write to 0x20.
      @(posedge clk); #1;
      ce_i = 1'b1; we_i = 1'b1; addr_i = 32'h20; sel_i = 4'b1111; data_i = 32'hCAFEF00D;
      @(posedge clk); #1;
      rst = 1'b0;
      ce_i = 1'b0;
      #1;
      chk("midreset_data", data_o, 32'h0);
      chk("midreset_ack", {31'b0, ack_o}, 32'h0);
      chk("midreset_err", {31'b0, err_o}, 32'h0);
      chk("midreset_stall", {31'b0, stallreq_o}, 32'h0);
      @(posedge clk); #1;
      rst = 1'b1;
      last_rd = 32'h0;
      do_req(1'b0, 32'h20, 4'b1111, 32'h0, 32'h12345678, 1'b0);

      do_req(1'b1, 32'h22, 4'b1111, 32'h0BADF00D, 32'h0, ALIGN);
      do_req(1'b0, 32'h20, 4'b1111, 32'h0, ALIGN ? 32'h12345678 : 32'h0BADF00D, 1'b0);

      repeat (4) @(posedge clk);
      #1;
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
